rf_wr_arbiter: RTL and testbench

//  Shares the single register-file write port (WrEn/Rw/busW) between the pipeline

---
 rtl/rf_wr_arbiter_if.sv | 52 +++++
 rtl/rf_wr_arbiter.sv | 107 ++++++++++
 tb/tb_rf_wr_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wr_arbiter_if.sv
// rf_wr_arbiter_if
//  Bundles the register-file write arbiter's request ports, scoreboard and
//  rf write port so producers, the arbiter and the hazard unit share one bus.
//  master : requester side (drives A/B writes and claims, observes readies,
//           busy and the rf write port)
//  slave  : arbiter side (rf_wr_arbiter)
//  Signals:
//   a_valid/a_ready/a_rw/a_data          writeback-stage write request
//   b_valid/b_ready/b_rw/b_data          long-latency unit write request
//   claim_valid/claim_ready/claim_rw     B-unit announcement of a future write
//   busy                                 per-register pending-B-write scoreboard
//   WrEn/Rw/busW                         registered rf write port
interface rf_wr_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic                 a_valid;
    logic                 a_ready;
    logic [AW-1:0]        a_rw;
    logic [DW-1:0]        a_data;

    logic                 b_valid;
    logic                 b_ready;
    logic [AW-1:0]        b_rw;
    logic [DW-1:0]        b_data;

    logic                 claim_valid;
    logic                 claim_ready;
    logic [AW-1:0]        claim_rw;

    logic [(1<<AW)-1:0]   busy;

    logic                 WrEn;
    logic [AW-1:0]        Rw;
    logic [DW-1:0]        busW;

    modport master (
        output a_valid, a_rw, a_data,
        output b_valid, b_rw, b_data,
        output claim_valid, claim_rw,
        input  a_ready, b_ready, claim_ready, busy,
        input  WrEn, Rw, busW
    );

    modport slave (
        input  a_valid, a_rw, a_data,
        input  b_valid, b_rw, b_data,
        input  claim_valid, claim_rw,
        output a_ready, b_ready, claim_ready, busy,
        output WrEn, Rw, busW
    );
endinterface

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter
//  Shares the single register-file write port between the writeback stage
//  (port A, fixed priority) and a long-latency unit (port B). B is forced
//  through after STARVE_MAX consecutive stalled cycles. The rf write is
//  registered (latency 1). A pending-write scoreboard tracks registers that
//  B has claimed but not yet written, so hazard logic can stall on them.
//  Ports:
//   Clk  in  clock, all state updates on posedge
//   Rst  in  asynchronous, active-high reset
//   bus  rf_wr_arbiter_if.slave: A/B requests, claims, busy, WrEn/Rw/busW
module rf_wr_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 4    // 1..15
) (
    input  logic           Clk,
    input  logic           Rst,
    rf_wr_arbiter_if.slave bus
);
    localparam int         NREG       = 1 << AW;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]      starveCnt;
    logic            forceB;
    logic            accA;
    logic            accB;
    logic            claimGo;
    logic            doWrite;
    logic [AW-1:0]   winRw;
    logic [DW-1:0]   winData;
    logic [NREG-1:0] setMask;
    logic [NREG-1:0] clrMask;

    logic            wrEnQ;
    logic [AW-1:0]   rwQ;
    logic [DW-1:0]   busWQ;
    logic [NREG-1:0] busyQ;

    // A owns the port unless B has waited STARVE_MAX cycles in a row.
    // The two accepts are mutually exclusive by construction: when forceB
    // A is not ready, otherwise B is ready only while A is idle.
    assign forceB      = (starveCnt == STARVE_LIM);
    assign bus.a_ready = !forceB;
    assign bus.b_ready = forceB | !bus.a_valid;
    assign accA        = bus.a_valid & bus.a_ready;
    assign accB        = bus.b_valid & bus.b_ready;

    // r0 is hard-wired: claims on it are always accepted and never tracked.
    assign bus.claim_ready = !busyQ[bus.claim_rw] | (bus.claim_rw == '0);
    assign claimGo         = bus.claim_valid & bus.claim_ready & (bus.claim_rw != '0);

    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        winRw   = bus.a_rw;
        winData = bus.a_data;
        setMask = '0;
        clrMask = '0;
        if (accB) begin
            winRw   = bus.b_rw;
            winData = bus.b_data;
            clrMask[bus.b_rw] = 1'b1;
        end
        if (claimGo) begin
            setMask[bus.claim_rw] = 1'b1;
        end
    end

    // An accepted write to r0 is consumed but never reaches the rf.
    assign doWrite = (accA | accB) & (winRw != '0);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            // NOTE: busy is a flop vector, not RAM, and must be reset: claims
            // are lost on reset and stale bits would stall the pipeline forever.
            wrEnQ     <= 1'b0;
            rwQ       <= '0;
            busWQ     <= '0;
            busyQ     <= '0;
            starveCnt <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples pre-edge values regardless of statement order.
            wrEnQ <= doWrite;
            if (doWrite) begin
                rwQ   <= winRw;
                busWQ <= winData;
            end

            // Set is applied after clear: a same-cycle re-claim of the
            // register B is writing leaves the bit set.
            busyQ <= (busyQ & ~clrMask) | setMask;

            // Counts only uninterrupted stalls of a valid B request.
            if (accB || !bus.b_valid) begin
                starveCnt <= '0;
            end else if (starveCnt != STARVE_LIM) begin
                starveCnt <= starveCnt + 4'd1;
            end
        end
    end

    assign bus.WrEn = wrEnQ;
    assign bus.Rw   = rwQ;
    assign bus.busW = busWQ;
    assign bus.busy = busyQ;
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter
//  Directed scenarios with literal expectations, then randomized A/B/claim
//  traffic (with valid/ready holding and a mid-run reset). A behavioural
//  model tracks the scoreboard as a set of pending registers, the length of
//  B's current stall streak and the last rf write; one compare process
//  checks every DUT output against it on each falling edge.
module tb_rf_wr_arbiter;
    localparam int DW         = 32;
    localparam int AW         = 5;
    localparam int STARVE_MAX = 4;
    localparam int NREG       = 1 << AW;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   running = 1'b1;

    rf_wr_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    rf_wr_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit              mPending [NREG];   // registers claimed by B, write not yet done
    int              mStall;            // consecutive cycles B has been refused
    bit              mWrEn;
    logic [AW-1:0]   mRw;
    logic [DW-1:0]   mData;

    function automatic logic [NREG-1:0] pendingVec();
        logic [NREG-1:0] v;
        v = '0;
        for (int r = 0; r < NREG; r++) v[r] = mPending[r];
        return v;
    endfunction

    initial begin
        foreach (mPending[r]) mPending[r] = 1'b0;
        mStall = 0; mWrEn = 1'b0; mRw = '0; mData = '0;
        forever begin
            @(posedge Clk or posedge Rst);
            if (Rst) begin
                foreach (mPending[r]) mPending[r] = 1'b0;
                mStall = 0; mWrEn = 1'b0; mRw = '0; mData = '0;
            end else begin
                bit bForced, aGo, bGo, cGo;
                bForced = (mStall == STARVE_MAX);
                aGo = bus.a_valid && !bForced;
                bGo = bus.b_valid && (bForced || !bus.a_valid);
                cGo = bus.claim_valid && bus.claim_rw != 0 && !mPending[bus.claim_rw];
                mWrEn = 1'b0;
                if (aGo && bus.a_rw != 0) begin
                    mWrEn = 1'b1; mRw = bus.a_rw; mData = bus.a_data;
                end
                if (bGo && bus.b_rw != 0) begin
                    mWrEn = 1'b1; mRw = bus.b_rw; mData = bus.b_data;
                end
                if (bus.b_valid && !bGo) mStall = (mStall < STARVE_MAX) ? mStall + 1 : mStall;
                else                     mStall = 0;
                if (bGo) mPending[bus.b_rw] = 1'b0;
                if (cGo) mPending[bus.claim_rw] = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge Clk);
            if (running && !Rst) begin
                bit bForced;
                bForced = (mStall == STARVE_MAX);
                check("cmp a_ready", bus.a_ready, !bForced);
                check("cmp b_ready", bus.b_ready, bForced || !bus.a_valid);
                check("cmp claim_ready", bus.claim_ready,
                      !mPending[bus.claim_rw] || bus.claim_rw == 0);
                check("cmp WrEn", bus.WrEn, mWrEn);
                check("cmp busy", bus.busy, pendingVec());
                if (mWrEn) begin
                    check("cmp Rw", bus.Rw, mRw);
                    check("cmp busW", bus.busW, mData);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic nextCycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.a_valid = 1'b0; bus.a_rw = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_rw = '0; bus.b_data = '0;
        bus.claim_valid = 1'b0; bus.claim_rw = '0;
    endtask

    // A and B held valid from a zero starve count: B refused STARVE_MAX
    // cycles, forced on the next, then A resumes.
    task automatic starveSeq(input string tag);
        bus.a_valid = 1'b1; bus.a_rw = 5'd3; bus.a_data = 32'h33;
        bus.b_valid = 1'b1; bus.b_rw = 5'd4; bus.b_data = 32'h44;
        for (int i = 0; i < STARVE_MAX; i++) begin
            #1;
            check({tag, " b_ready stalled"}, bus.b_ready, 1'b0);
            check({tag, " a_ready granted"}, bus.a_ready, 1'b1);
            nextCycle();
        end
        #1;
        check({tag, " b_ready forced"}, bus.b_ready, 1'b1);
        check({tag, " a_ready blocked"}, bus.a_ready, 1'b0);
        nextCycle();
        check({tag, " B WrEn"}, bus.WrEn, 1'b1);
        check({tag, " B Rw"}, bus.Rw, 5'd4);
        check({tag, " B busW"}, bus.busW, 32'h44);
        bus.b_valid = 1'b0;
        #1;
        check({tag, " a_ready after B"}, bus.a_ready, 1'b1);
        nextCycle();
        check({tag, " A Rw after B"}, bus.Rw, 5'd3);
        check({tag, " A busW after B"}, bus.busW, 32'h33);
        bus.a_valid = 1'b0;
    endtask

    initial begin
        int  aPct;
        bit  aDone;
        bit  bDone;

        idleInputs();
        #3;
        check("reset WrEn", bus.WrEn, 1'b0);
        check("reset Rw", bus.Rw, 5'd0);
        check("reset busW", bus.busW, 32'd0);
        check("reset busy", bus.busy, 32'd0);
        #9 Rst = 1'b0;
        nextCycle();

        // 1. A only
        bus.a_valid = 1'b1; bus.a_rw = 5'd10; bus.a_data = 32'd7;
        #2 check("t1 a_ready", bus.a_ready, 1'b1);
        nextCycle();
        check("t1 WrEn", bus.WrEn, 1'b1);
        check("t1 Rw", bus.Rw, 5'd10);
        check("t1 busW", bus.busW, 32'd7);
        bus.a_valid = 1'b0;
        nextCycle();
        check("t1 WrEn idle", bus.WrEn, 1'b0);
        check("t1 Rw held", bus.Rw, 5'd10);

        // 2. starvation guard
        starveSeq("t2");
        nextCycle();

        // 3. claim, repeat claim, B write releases it
        bus.claim_valid = 1'b1; bus.claim_rw = 5'd11;
        #2 check("t3 claim_ready first", bus.claim_ready, 1'b1);
        nextCycle();
        check("t3 busy11 set", bus.busy[11], 1'b1);
        #1 check("t3 claim_ready repeat", bus.claim_ready, 1'b0);
        bus.claim_valid = 1'b0;
        bus.b_valid = 1'b1; bus.b_rw = 5'd11; bus.b_data = 32'd15;
        #1 check("t3 b_ready", bus.b_ready, 1'b1);
        nextCycle();
        check("t3 WrEn", bus.WrEn, 1'b1);
        check("t3 Rw", bus.Rw, 5'd11);
        check("t3 busW", bus.busW, 32'd15);
        check("t3 busy11 cleared", bus.busy[11], 1'b0);
        bus.b_valid = 1'b0;

        // 4. r0 writes and claims
        bus.a_valid = 1'b1; bus.a_rw = 5'd0; bus.a_data = 32'hFFFF_FFFF;
        bus.claim_valid = 1'b1; bus.claim_rw = 5'd0;
        #2;
        check("t4 a_ready", bus.a_ready, 1'b1);
        check("t4 claim_ready r0", bus.claim_ready, 1'b1);
        nextCycle();
        check("t4 WrEn r0", bus.WrEn, 1'b0);
        check("t4 busy unchanged", bus.busy, 32'd0);
        bus.a_valid = 1'b0; bus.claim_valid = 1'b0;

        // 5. same-cycle claim and B write to r5: set wins
        bus.claim_valid = 1'b1; bus.claim_rw = 5'd5;
        bus.b_valid = 1'b1; bus.b_rw = 5'd5; bus.b_data = 32'h55;
        nextCycle();
        check("t5 WrEn", bus.WrEn, 1'b1);
        check("t5 Rw", bus.Rw, 5'd5);
        check("t5 busy5 set wins", bus.busy[5], 1'b1);
        bus.claim_valid = 1'b0; bus.b_valid = 1'b0;

        // 6. async reset mid-cycle with a write out and a partial stall streak
        bus.a_valid = 1'b1; bus.a_rw = 5'd9; bus.a_data = 32'h99;
        bus.b_valid = 1'b1; bus.b_rw = 5'd6; bus.b_data = 32'h66;
        nextCycle();
        nextCycle();
        check("t6 WrEn before rst", bus.WrEn, 1'b1);
        check("t6 busy5 before rst", bus.busy[5], 1'b1);
        #2 Rst = 1'b1;
        #1;
        check("t6 WrEn in rst", bus.WrEn, 1'b0);
        check("t6 busy in rst", bus.busy, 32'd0);
        check("t6 Rw in rst", bus.Rw, 5'd0);
        idleInputs();
        #2 Rst = 1'b0;
        nextCycle();
        starveSeq("t6");
        nextCycle();

        // Randomized traffic; held requests stay stable until accepted.
        for (int blk = 0; blk < 4; blk++) begin
            aPct = (blk % 2 == 0) ? 90 : 40;
            for (int i = 0; i < 600; i++) begin
                #2;
                aDone = !bus.a_valid || bus.a_ready;
                bDone = !bus.b_valid || bus.b_ready;
                nextCycle();
                if (aDone) begin
                    bus.a_valid = ($urandom_range(0, 99) < aPct);
                    bus.a_rw    = AW'($urandom_range(0, 7));
                    bus.a_data  = $urandom;
                end
                if (bDone) begin
                    bus.b_valid = ($urandom_range(0, 99) < 45);
                    bus.b_rw    = AW'($urandom_range(0, 7));
                    bus.b_data  = $urandom;
                end
                bus.claim_valid = ($urandom_range(0, 99) < 35);
                bus.claim_rw    = AW'($urandom_range(0, 7));
            end
            if (blk == 1) begin
                #2 Rst = 1'b1;
                #3 Rst = 1'b0;
            end
        end

        idleInputs();
        nextCycle();
        nextCycle();
        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
